// File: rtl/mac_feeder_if.sv
// Operand/result bus between the MAC feeder (master) and its environment:
// buffer write port, stream control, operand streams to the MAC and the MAC result.
interface mac_feeder_if #(
   parameter int DATA_W  = 4,
   parameter int VEC_LEN = 8,
   parameter int ACC_W   = 11
);
   localparam int AW = $clog2(VEC_LEN);

   logic              wr_en;
   logic              wr_sel;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              start;
   logic [1:0]        skew;
   logic              busy;
   logic              done;
   logic              timeout;
   logic [ACC_W-1:0]  result;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              in_valid_a;
   logic              in_valid_b;
   logic [ACC_W-1:0]  mac_out;
   logic              out_valid;

   modport master (
      input  wr_en, wr_sel, wr_addr, wr_data, start, skew, mac_out, out_valid,
      output busy, done, timeout, result, in_a, in_b, in_valid_a, in_valid_b
   );

   modport slave (
      output wr_en, wr_sel, wr_addr, wr_data, start, skew, mac_out, out_valid,
      input  busy, done, timeout, result, in_a, in_b, in_valid_a, in_valid_b
   );
endinterface

// File: rtl/mac_feeder.sv
// MAC operand feeder: buffers two signed vectors, streams them (b optionally lagged),
// then waits a bounded number of cycles for the MAC result.
module mac_feeder #(
   parameter int DATA_W  = 4,
   parameter int VEC_LEN = 8,
   parameter int ACC_W   = 11,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   mac_feeder_if.master bus
);
   localparam int AW = $clog2(VEC_LEN);
   localparam int CW = $clog2(VEC_LEN + 4) + 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

   state_t                         state_q, state_d;
   logic [VEC_LEN-1:0][DATA_W-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d;
   logic [1:0]                     skew_q, skew_d;
   logic [CW-1:0]                  scnt_q, scnt_d;
   logic [WW-1:0]                  wcnt_q, wcnt_d;
   logic                           busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
   logic [ACC_W-1:0]               result_q, result_d;
   logic [DATA_W-1:0]              in_a_q, in_a_d, in_b_q, in_b_d;
   logic                           va_q, va_d, vb_q, vb_d;

   logic [CW-1:0] idx_b, last_cnt;
   logic          wr_ok, a_live, b_live, stream_end, expired;

   // One stream counter drives both lanes; the b lane is the same count shifted by skew.
   assign idx_b      = scnt_q - CW'(skew_q);
   assign last_cnt   = CW'(VEC_LEN - 1) + CW'(skew_q);
   assign a_live     = scnt_q < CW'(VEC_LEN);
   assign b_live     = (scnt_q >= CW'(skew_q)) && (idx_b < CW'(VEC_LEN));
   assign stream_end = scnt_q == last_cnt;
   assign expired    = wcnt_q == WW'(TIMEOUT - 1);
   assign wr_ok      = bus.wr_en && (32'(bus.wr_addr) < VEC_LEN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (bus.start) state_d = STREAM;
         STREAM:   if (stream_end) state_d = WAIT_RES;
         WAIT_RES: if (bus.out_valid || expired) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      buf_a_d   = buf_a_q;
      buf_b_d   = buf_b_q;
      skew_d    = skew_q;
      scnt_d    = scnt_q;
      wcnt_d    = wcnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      timeout_d = timeout_q;
      result_d  = result_q;
      in_a_d    = '0;
      in_b_d    = '0;
      va_d      = 1'b0;
      vb_d      = 1'b0;
      case (state_q)
         IDLE: begin
            // The write lands at the same edge as start, so the stream sees it.
            if (wr_ok) begin
               if (bus.wr_sel) buf_b_d[bus.wr_addr] = bus.wr_data;
               else            buf_a_d[bus.wr_addr] = bus.wr_data;
            end
            if (bus.start) begin
               skew_d    = bus.skew;
               scnt_d    = '0;
               timeout_d = 1'b0;
               busy_d    = 1'b1;
            end
         end
         STREAM: begin
            if (a_live) begin
               va_d   = 1'b1;
               in_a_d = buf_a_q[scnt_q[AW-1:0]];
            end
            if (b_live) begin
               vb_d   = 1'b1;
               in_b_d = buf_b_q[idx_b[AW-1:0]];
            end
            scnt_d = scnt_q + 1'b1;
            wcnt_d = '0;
         end
         WAIT_RES: begin
            wcnt_d = wcnt_q + 1'b1;
            // A result arriving on the expiry cycle still counts as a capture.
            if (bus.out_valid) begin
               result_d = bus.mac_out;
               done_d   = 1'b1;
               busy_d   = 1'b0;
            end else if (expired) begin
               timeout_d = 1'b1;
               busy_d    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_a_q   <= '0;
         buf_b_q   <= '0;
         skew_q    <= '0;
         scnt_q    <= '0;
         wcnt_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         result_q  <= '0;
         in_a_q    <= '0;
         in_b_q    <= '0;
         va_q      <= 1'b0;
         vb_q      <= 1'b0;
      end else begin
         buf_a_q   <= buf_a_d;
         buf_b_q   <= buf_b_d;
         skew_q    <= skew_d;
         scnt_q    <= scnt_d;
         wcnt_q    <= wcnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         result_q  <= result_d;
         in_a_q    <= in_a_d;
         in_b_q    <= in_b_d;
         va_q      <= va_d;
         vb_q      <= vb_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.result     = result_q;
   assign bus.in_a       = in_a_q;
   assign bus.in_b       = in_b_q;
   assign bus.in_valid_a = va_q;
   assign bus.in_valid_b = vb_q;
endmodule

// File: tb/tb_mac_feeder.sv
// Randomized scoreboard bench for mac_feeder: a behavioural MAC sits on the operand bus,
// a reference buffer model predicts every stream cycle and every completion.
module tb_mac_feeder;
   localparam int DW = 4;
   localparam int VL = 8;
   localparam int AC = 11;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mac_feeder_if #(.DATA_W(DW), .VEC_LEN(VL), .ACC_W(AC)) bus ();

   mac_feeder #(.DATA_W(DW), .VEC_LEN(VL), .ACC_W(AC), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .bus(bus.master)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [VL-1:0][DW-1:0] a;
      logic [VL-1:0][DW-1:0] b;
      logic [1:0]            s;
      int                    edge0;
   } strm_t;

   typedef struct packed {
      logic to;
      int   val;
      int   cyc;
   } exp_t;

   strm_t stq[$];
   exp_t  sbq[$];

   int ref_a[VL];
   int ref_b[VL];
   int ref_res  = 0;
   bit ref_busy = 0;
   int mac_lat  = 2;
   bit stray    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int sx(input int d);
      logic signed [DW-1:0] t;
      t = d[DW-1:0];
      return int'(t);
   endfunction

   function automatic int dot();
      int s = 0;
      for (int k = 0; k < VL; k++) s += ref_a[k] * ref_b[k];
      return s;
   endfunction

   // Behavioural MAC: collects both streams, answers mac_lat cycles later (negative = never).
   initial begin
      int qa[$];
      int qb[$];
      int cnt;
      int acc;
      cnt = -1;
      acc = 0;
      bus.out_valid = 1'b0;
      bus.mac_out   = '0;
      forever begin
         @(negedge clk);
         bus.out_valid = 1'b0;
         bus.mac_out   = AC'($urandom);
         if (reset) begin
            qa.delete();
            qb.delete();
            cnt = -1;
         end else begin
            if (bus.in_valid_a) qa.push_back(int'($signed(bus.in_a)));
            if (bus.in_valid_b) qb.push_back(int'($signed(bus.in_b)));
            if (qa.size() == VL && qb.size() == VL) begin
               acc = 0;
               for (int k = 0; k < VL; k++) acc += qa[k] * qb[k];
               qa.delete();
               qb.delete();
               cnt = mac_lat;
            end
            if (stray) begin
               bus.out_valid = 1'b1;
               stray = 1'b0;
            end else if (cnt == 0) begin
               bus.out_valid = 1'b1;
               bus.mac_out   = AC'(acc);
               cnt = -1;
            end else if (cnt > 0) begin
               cnt--;
            end
         end
      end
   end

   // Monitor: cycle-exact stream pattern plus completion scoreboard.
   initial begin
      strm_t f;
      exp_t  e;
      int    n, s;
      bit    pto;
      logic  va, vb;
      logic [DW-1:0] ea, eb;
      pto = 1'b0;
      forever begin
         @(negedge clk);
         va = 1'b0; vb = 1'b0; ea = '0; eb = '0;
         if (!reset && stq.size() > 0) begin
            f = stq[0];
            s = int'(f.s);
            n = cyc - f.edge0;
            if (n >= 1 && n <= VL) begin
               va = 1'b1;
               ea = f.a[n-1];
            end
            if (n >= 1 + s && n <= VL + s) begin
               vb = 1'b1;
               eb = f.b[n-1-s];
            end
            if (n >= 0 && n <= VL + s) chk("busy_in_stream", int'(bus.busy), 1);
            if (n > VL + s) void'(stq.pop_front());
         end
         chk("stream_a", int'({bus.in_valid_a, bus.in_a}), int'({va, ea}));
         chk("stream_b", int'({bus.in_valid_b, bus.in_b}), int'({vb, eb}));
         if (bus.done) begin
            if (sbq.size() == 0) chk("unexpected_done", int'(bus.done), 0);
            else begin
               e = sbq.pop_front();
               chk("done_not_timeout", int'(bus.timeout), int'(e.to));
               chk("done_result", int'($signed(bus.result)), e.val);
               chk("busy_at_done", int'(bus.busy), 0);
            end
         end
         if (bus.timeout && !pto) begin
            if (sbq.size() == 0) chk("unexpected_timeout", int'(bus.timeout), 0);
            else begin
               e = sbq.pop_front();
               chk("timeout_not_done", int'(bus.done), e.to ? 0 : 1);
               chk("timeout_result_kept", int'($signed(bus.result)), e.val);
               chk("timeout_cycle", cyc, e.cyc);
               chk("busy_at_timeout", int'(bus.busy), 0);
            end
         end
         pto = bus.timeout;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Drive one cycle of write/start; the reference only honours them while idle.
   task automatic issue(input bit we, input bit sel, input int addr, input int data,
                        input bit st, input int s);
      strm_t sr;
      exp_t  e;
      bus.wr_en   = we;
      bus.wr_sel  = sel;
      bus.wr_addr = 3'(addr);
      bus.wr_data = DW'(data);
      bus.start   = st;
      bus.skew    = 2'(s);
      if (we && !ref_busy) begin
         if (sel) ref_b[addr] = sx(data);
         else     ref_a[addr] = sx(data);
      end
      if (st && !ref_busy) begin
         sr.edge0 = cyc + 1;
         sr.s     = 2'(s);
         for (int k = 0; k < VL; k++) begin
            sr.a[k] = DW'(ref_a[k]);
            sr.b[k] = DW'(ref_b[k]);
         end
         stq.push_back(sr);
         e.to  = (mac_lat < 0) || (mac_lat >= TO);
         e.val = e.to ? ref_res : dot();
         e.cyc = cyc + 1 + VL + s + TO;
         if (!e.to) ref_res = e.val;
         sbq.push_back(e);
         ref_busy = 1'b1;
      end
      tick();
      bus.wr_en   = 1'b0;
      bus.start   = 1'b0;
      bus.wr_data = DW'($urandom);
      bus.skew    = 2'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (sbq.size() != 0 && t < 300) begin
         tick();
         t++;
      end
      if (sbq.size() != 0) begin
         chk("completion_wait_expired", sbq.size(), 0);
         sbq.delete();
         stq.delete();
      end
      ref_busy = 1'b0;
      tick();
   endtask

   task automatic load_const(input bit sel, input int v);
      for (int k = 0; k < VL; k++) issue(1'b1, sel, k, v, 1'b0, 0);
   endtask

   task automatic run(input int s, input int lat);
      mac_lat = lat;
      issue(1'b0, 1'b0, 0, 0, 1'b1, s);
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < VL; k++) begin ref_a[k] = 0; ref_b[k] = 0; end
      bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.skew = '0;
      repeat (3) tick();
      chk("reset_outputs", int'({bus.busy, bus.done, bus.timeout, bus.in_valid_a,
                                 bus.in_valid_b, bus.in_a, bus.in_b, bus.result}), 0);
      reset = 1'b0;
      tick();

      // Basic dot products, skew 0
      load_const(1'b0, 1); load_const(1'b1, 2);
      run(0, 2);
      chk("t1_result", int'($signed(bus.result)), 16);
      load_const(1'b0, -8); load_const(1'b1, 7);
      run(0, 0);
      chk("t2_result_neg", int'($signed(bus.result)), -448);
      load_const(1'b1, -8);
      run(0, 5);
      chk("t2_result_pos", int'($signed(bus.result)), 512);

      // Maximum skew with a ramp (8 wraps to -8 at 4 bits)
      for (int k = 0; k < VL; k++) begin
         issue(1'b1, 1'b0, k, k + 1, 1'b0, 0);
         issue(1'b1, 1'b1, k, k + 1, 1'b0, 0);
      end
      run(3, 1);
      chk("t3_result", int'($signed(bus.result)), 204);

      // Timeout, stickiness and clear on next start; expiry-boundary latencies
      run(0, -1);
      repeat (3) tick();
      chk("timeout_sticky", int'(bus.timeout), 1);
      chk("timeout_result_unchanged", int'($signed(bus.result)), 204);
      mac_lat = 3;
      issue(1'b0, 1'b0, 0, 0, 1'b1, 2);
      tick();
      chk("timeout_cleared", int'(bus.timeout), 0);
      wait_idle();
      run(1, 15);
      run(2, 16);
      stray = 1'b1;
      repeat (4) tick();
      chk("idle_out_valid_ignored", int'($signed(bus.result)), ref_res);

      // Reset in stream cycle 4
      mac_lat = 2;
      issue(1'b0, 1'b0, 0, 0, 1'b1, 1);
      repeat (4) tick();
      #2 reset = 1'b1;
      #1 chk("reset_drops_stream", int'({bus.in_valid_a, bus.in_valid_b, bus.busy}), 0);
      stq.delete(); sbq.delete();
      for (int k = 0; k < VL; k++) begin ref_a[k] = 0; ref_b[k] = 0; end
      ref_res = 0; ref_busy = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      run(0, 1);
      chk("t5_cleared_result", int'($signed(bus.result)), 0);

      // start/wr_en while busy are dropped; write + start together in idle
      for (int k = 0; k < VL; k++) begin
         issue(1'b1, 1'b0, k, $urandom_range(0, 15), 1'b0, 0);
         issue(1'b1, 1'b1, k, $urandom_range(0, 15), 1'b0, 0);
      end
      mac_lat = 4;
      issue(1'b0, 1'b0, 0, 0, 1'b1, 1);
      tick();
      issue(1'b1, 1'b0, 0, 3, 1'b1, 3);
      issue(1'b1, 1'b1, 5, 6, 1'b0, 0);
      wait_idle();
      mac_lat = 2;
      issue(1'b1, 1'b0, 2, 5, 1'b1, 2);
      wait_idle();

      // Randomized transactions
      for (int t = 0; t < 30; t++) begin
         int nw;
         int lat;
         nw = $urandom_range(0, 10);
         for (int w = 0; w < nw; w++)
            issue(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, VL - 1),
                  $urandom_range(0, 15), 1'b0, 0);
         case ($urandom_range(0, 9))
            0:       lat = -1;
            1:       lat = 15;
            2:       lat = 16;
            default: lat = $urandom_range(0, 8);
         endcase
         mac_lat = lat;
         issue(1'b0, 1'b0, 0, 0, 1'b1, $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            issue(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, VL - 1),
                  $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
         wait_idle();
      end

      repeat (4) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
